// File: rtl/yarp_pkg.sv
// Shared types and helpers for the yarp core; the MDU op encoding matches RV32M funct3.
package yarp_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_t;

  function automatic logic is_div(input mdu_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input mdu_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(input mdu_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input mdu_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/yarp_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
module yarp_mdu
  import yarp_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       op_sel_i,
  input  logic [WIDTH-1:0] opr_a_i,
  input  logic [WIDTH-1:0] opr_b_i,
  input  logic             flush_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] res_o,
  output logic             busy_o
);

  localparam int unsigned      CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e             state_q, state_d;
  mdu_op_t            op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               neg_q, neg_d;
  logic               negr_q, negr_d;
  logic [WIDTH-1:0]   res_q, res_d;

  mdu_op_t            op_in;
  logic               sa, sb, div_zero, div_ovf, div_step;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     div_shift, add_x, add_y, add_s;
  logic [2*WIDTH-1:0] acc_mul, acc_div, acc_step, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res_step;

  // Operand conditioning for the accept cycle
  always_comb begin
    op_in    = mdu_op_t'(op_sel_i);
    sa       = is_signed_a(op_in) & opr_a_i[WIDTH-1];
    sb       = is_signed_b(op_in) & opr_b_i[WIDTH-1];
    a_abs    = sa ? ('0 - opr_a_i) : opr_a_i;
    b_abs    = sb ? ('0 - opr_b_i) : opr_b_i;
    div_zero = (opr_b_i == '0);
    div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (opr_a_i == INT_MIN) && (opr_b_i == '1);
  end

  // Single W+1-bit adder: adds the multiplicand for multiply, subtracts the divisor for divide
  always_comb begin
    div_step  = is_div(op_q);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    add_x     = div_step ? div_shift : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    add_y     = div_step ? ~{1'b0, opb_q} : {1'b0, opb_q};
    add_s     = add_x + add_y + {{WIDTH{1'b0}}, div_step};
    acc_mul   = acc_q[0] ? {add_s, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    acc_div   = add_s[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                             : {add_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    acc_step  = div_step ? acc_div : acc_mul;
    prod_fix  = neg_q ? ('0 - acc_step) : acc_step;
    quo_fix   = neg_q ? ('0 - acc_step[WIDTH-1:0]) : acc_step[WIDTH-1:0];
    rem_fix   = negr_q ? ('0 - acc_step[2*WIDTH-1:WIDTH]) : acc_step[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MULH, OP_MULHSU, OP_MULHU: res_step = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              res_step = quo_fix;
      OP_REM, OP_REMU:              res_step = rem_fix;
      default:                      res_step = acc_step[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && !flush_i) begin
          op_d   = op_in;
          cnt_d  = CNT_INIT;
          neg_d  = sa ^ sb;
          negr_d = sa;
          if (is_div(op_in) && div_zero) begin
            res_d   = is_rem(op_in) ? opr_a_i : '1;
            state_d = S_DONE;
          end else if (div_ovf) begin
            res_d   = (op_in == OP_DIV) ? opr_a_i : '0;
            state_d = S_DONE;
          end else begin
            // Multiply keeps the multiplier in the low half; divide keeps the dividend there
            acc_d   = {{WIDTH{1'b0}}, is_div(op_in) ? a_abs : b_abs};
            opb_d   = is_div(op_in) ? b_abs : a_abs;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          res_d   = res_step;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign res_o       = res_q;

endmodule

// File: tb/tb_yarp_mdu.sv
// Self-checking bench for yarp_mdu: directed vector table, random ops vs. arithmetic model, corner sequences.
module tb_yarp_mdu;
  import yarp_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, req_valid, req_ready, flush, rsp_valid, rsp_ready, busy;
  logic [2:0]   op_sel;
  logic [W-1:0] opr_a, opr_b, res;
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  yarp_mdu #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .op_sel_i   (op_sel),
    .opr_a_i    (opr_a),
    .opr_b_i    (opr_b),
    .flush_i    (flush),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .res_o      (res),
    .busy_o     (busy)
  );

  typedef struct {
    mdu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference written directly from the RV32M rules
  function automatic logic [31:0] ref_mdu(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    int     sa, sb;
    longint la_s, lb_s, la_u, lb_u, p;
    sa   = a;
    sb   = b;
    la_s = sa;
    lb_s = sb;
    la_u = {32'b0, a};
    lb_u = {32'b0, b};
    case (op)
      OP_MUL:    begin p = la_u * lb_u; return p[31:0];  end
      OP_MULH:   begin p = la_s * lb_s; return p[63:32]; end
      OP_MULHSU: begin p = la_s * lb_u; return p[63:32]; end
      OP_MULHU:  begin p = la_u * lb_u; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return 32'(sa / sb);
      end
      OP_DIVU: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU} && b == 0) return 1;
    if (op inside {OP_DIV, OP_REM} && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return W + 1;
  endfunction

  // Counts edges from the accept edge (=1) until rsp_valid is seen; bounded
  task automatic wait_rsp(output int lat, output bit busy_ok);
    lat     = 1;
    busy_ok = 1'b1;
    while (!rsp_valid && lat < 100) begin
      if (req_ready !== 1'b0 || busy !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat);
    bit busy_ok;
    op_sel    = op;
    opr_a     = a;
    opr_b     = b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    opr_a     = $urandom;
    opr_b     = $urandom;
    op_sel    = 3'($urandom);
    wait_rsp(lat, busy_ok);
    r = res;
    check("busy_not_ready_during_op", busy_ok, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("idle_after_handshake", {rsp_valid, req_ready, busy}, 3'b010);
    check("res_held_in_idle", res, r);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, exp, a, b, held;
    int          lat;
    bit          ok;
    mdu_op_t     op;

    vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{OP_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{OP_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[3]  = '{OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[4]  = '{OP_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{OP_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{OP_DIVU,   32'hFFFFFFFF,   32'd2,        32'h7FFFFFFF, 33};
    vecs[7]  = '{OP_REMU,   32'd100,        32'd7,        32'd2,        33};
    vecs[8]  = '{OP_DIV,    32'd5,          32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{OP_REM,    32'd5,          32'd0,        32'd5,        1};
    vecs[10] = '{OP_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{OP_REM,    32'h80000000,   32'hFFFFFFFF, 32'h0,        1};
    vecs[12] = '{OP_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 1};
    vecs[13] = '{OP_REMU,   32'd9,          32'd0,        32'd9,        1};
    vecs[14] = '{OP_DIVU,   32'h80000000,   32'hFFFFFFFF, 32'h0,        33};
    vecs[15] = '{OP_MUL,    32'd3,          32'd4,        32'd12,       33};

    reset     = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    flush     = 1'b0;
    op_sel    = '0;
    opr_a     = '0;
    opr_b     = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_flags", {rsp_valid, req_ready, busy}, 3'b010);
    check("reset_res", res, 32'h0);

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat);
      check($sformatf("vec%0d_res", i), r, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
    end

    for (int i = 0; i < 300; i++) begin
      op = mdu_op_t'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       a = 32'h80000000;
        1:       a = 32'($signed(8'($urandom)));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'hFFFFFFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      exp = ref_mdu(op, a, b);
      run_op(op, a, b, r, lat);
      check($sformatf("rand%0d_op%0d_res", i, op), r, exp);
      check($sformatf("rand%0d_lat", i), 64'(lat), 64'(ref_lat(op, a, b)));
    end

    // Backpressure: response must hold while the consumer stalls
    op_sel    = OP_DIVU;
    opr_a     = 32'd100;
    opr_b     = 32'd7;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_rsp(lat, ok);
    check("bp_lat", 64'(lat), 64'd33);
    held = res;
    check("bp_res", held, 32'd14);
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || res !== held) ok = 1'b0;
    end
    check("bp_stable_5_cycles", ok, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_release_idle", {rsp_valid, req_ready, busy}, 3'b010);
    run_op(OP_MULHU, 32'hFFFFFFFF, 32'd2, r, lat);
    check("bp_next_req_res", r, 32'd1);

    // Flush 10 cycles into CALC
    op_sel    = OP_MUL;
    opr_a     = 32'd9;
    opr_b     = 32'd9;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
    check("flush_pre_busy", busy, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle", {rsp_valid, req_ready, busy}, 3'b010);
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("flush_no_response", ok, 1'b1);
    check("flush_res_kept", res, 32'd1);

    // Flush in IDLE blocks the accept
    req_valid = 1'b1;
    flush     = 1'b1;
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    check("flush_blocks_accept", {req_ready, busy}, 2'b10);

    // Reset mid-CALC
    op_sel    = OP_DIV;
    opr_a     = 32'd1000;
    opr_b     = 32'd3;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_mid_flags", {rsp_valid, req_ready, busy}, 3'b010);
    check("reset_mid_res", res, 32'h0);
    run_op(OP_MUL, 32'd3, 32'd4, r, lat);
    check("post_reset_mul", r, 32'd12);
    check("post_reset_lat", 64'(lat), 64'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
